// File: rtl/obj_scan_queue_pkg.sv
// Shared PPU types for the per-scanline sprite scan/queue.
//   scan_state_t : scanner FSM states
//   oam_entry_t  : one OAM entry as the scanner evaluates it
//   obj_hit_t    : per-sprite payload returned on a query hit
package obj_scan_queue_pkg;

    // Fixed payload index width; supports up to 64 OAM entries.
    localparam int unsigned OAM_IDX_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_READY = 2'd2
    } scan_state_t;

    // attrs[3:0] (palette/bank bits) play no part in line selection and are not carried.
    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
        logic [7:0] tile;
        logic [3:0] attrs_hi;
    } oam_entry_t;

    typedef struct packed {
        logic [2:0]           dy;
        logic [7:0]           tile;
        logic [3:0]           attrs;
        logic [OAM_IDX_W-1:0] oam_idx;
    } obj_hit_t;

    // Row of the sprite that lands on scanline ly, modulo 256.
    function automatic logic [7:0] obj_line_dy(input logic [7:0] ly,
                                               input logic [7:0] y_off,
                                               input logic [7:0] y);
        return ly + y_off - y;
    endfunction

endpackage

// File: rtl/obj_scan_queue_slot.sv
// One sprite slot: holds valid, x and the hit payload, and flags a query match.
//   clk, rst     : clock, synchronous active-low reset
//   clr          : invalidate (new scan)
//   wr_en        : capture wr_x / wr_data and become valid
//   inv          : invalidate after being returned by a query
//   q_x          : query X
//   valid, match : slot occupied / occupied and x == q_x
//   data         : stored payload
module obj_slot
    import obj_scan_queue_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] wr_x,
    input  obj_hit_t   wr_data,
    input  logic       inv,
    input  logic [7:0] q_x,
    output logic       valid,
    output logic       match,
    output obj_hit_t   data
);

    logic [7:0] x_q;

    // Slot storage; clear has priority over a write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            x_q   <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid <= 1'b1;
            x_q   <= wr_x;
            data  <= wr_data;
        end else if (inv) begin
            valid <= 1'b0;
        end
    end

    assign match = valid && (x_q == q_x);

endmodule

// File: rtl/obj_scan_queue.sv
// Scanline sprite selector: scans OAM for sprites on line ly, keeps up to
// NUM_SLOTS of them, then answers per-pixel X queries in OAM order.
//   clk, rst       : clock, synchronous active-low reset
//   start          : begin (or restart) a scan for ly / tall
//   ly, tall       : current line, 8x16 mode
//   oam_addr       : OAM word address; oam_d_in returns that word a cycle later
//   scan_done      : scan finished, queries accepted
//   count/overflow : sprites captured / visible sprite dropped for lack of slots
//   q_req, q_x     : query strobe and pixel X
//   q_hit, q_data  : registered query result
module obj_scan_queue
    import obj_scan_queue_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 10,
    parameter int unsigned OAM_ENTRIES = 40,
    parameter int unsigned Y_OFFSET    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [7:0]                       ly,
    input  logic                             tall,
    output logic [$clog2(2*OAM_ENTRIES)-1:0] oam_addr,
    input  logic [15:0]                      oam_d_in,
    output logic                             scan_done,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   count,
    output logic                             overflow,
    input  logic                             q_req,
    input  logic [7:0]                       q_x,
    output logic                             q_hit,
    output obj_hit_t                         q_data
);

    localparam int unsigned ADDR_W  = $clog2(2*OAM_ENTRIES);
    localparam int unsigned COUNT_W = $clog2(NUM_SLOTS+1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2*OAM_ENTRIES-1);

    scan_state_t state, state_nxt;
    logic        scanning, query_en;

    logic              last_issued;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        ebuf_x, ebuf_y;
    logic              tall_q;
    logic              last_consume;

    oam_entry_t entry;
    logic [7:0] dy;
    logic [3:0] dy_c;
    logic       visible;
    logic       odd_visible;
    logic       full;
    logic       do_write;
    obj_hit_t   wr_data;

    logic [NUM_SLOTS-1:0] slot_valid, slot_match;
    logic [NUM_SLOTS-1:0] wr_oh, hit_oh;
    obj_hit_t             slot_data [NUM_SLOTS];
    logic                 free_found, hit_found;
    obj_hit_t             hit_data;
    logic                 do_query;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign last_consume = rd_pend && (rd_addr_q == LAST_ADDR);

    // FSM next state; start always (re)enters SCAN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SCAN;
            ST_SCAN:  begin
                if (start)             state_nxt = ST_SCAN;
                else if (last_consume) state_nxt = ST_READY;
            end
            ST_READY: if (start) state_nxt = ST_SCAN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        scanning  = 1'b0;
        query_en  = 1'b0;
        scan_done = 1'b0;
        case (state)
            ST_SCAN:  scanning = 1'b1;
            ST_READY: begin
                query_en  = 1'b1;
                scan_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Odd-word evaluation: even half comes from the buffer, odd half is on oam_d_in now.
    always_comb begin
        entry.y        = ebuf_y;
        entry.x        = ebuf_x;
        entry.tile     = oam_d_in[7:0];
        entry.attrs_hi = oam_d_in[15:12];
    end

    assign dy      = obj_line_dy(ly, 8'(Y_OFFSET), entry.y);
    assign visible = tall_q ? (dy < 8'd16) : (dy < 8'd8);
    // attrs[6] is y-flip.
    assign dy_c    = entry.attrs_hi[2] ? ~dy[3:0] : dy[3:0];

    always_comb begin
        wr_data.dy      = dy_c[2:0];
        wr_data.tile    = tall_q ? {entry.tile[7:1], dy_c[3]} : entry.tile;
        wr_data.attrs   = entry.attrs_hi;
        wr_data.oam_idx = OAM_IDX_W'(rd_addr_q >> 1);
    end

    assign odd_visible = scanning && rd_pend && rd_addr_q[0] && visible;
    assign full        = (count == COUNT_W'(NUM_SLOTS));
    assign do_write    = odd_visible && !full && !start;

    // Lowest free slot.
    always_comb begin
        free_found = 1'b0;
        wr_oh      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_valid[i] && !free_found) begin
                free_found = 1'b1;
                wr_oh[i]   = 1'b1;
            end
        end
    end

    // Lowest matching slot; slots fill in OAM order, so this is the lowest oam_idx.
    always_comb begin
        hit_found = 1'b0;
        hit_oh    = '0;
        hit_data  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_match[i] && !hit_found) begin
                hit_found = 1'b1;
                hit_oh[i] = 1'b1;
                hit_data  = slot_data[i];
            end
        end
    end

    assign do_query = query_en && q_req && !start && hit_found;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        obj_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .clr     (start),
            .wr_en   (do_write & wr_oh[g]),
            .wr_x    (entry.x),
            .wr_data (wr_data),
            .inv     (do_query & hit_oh[g]),
            .q_x     (q_x),
            .valid   (slot_valid[g]),
            .match   (slot_match[g]),
            .data    (slot_data[g])
        );
    end

    // Scan address generation, one-cycle read pipeline and capture bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            oam_addr    <= '0;
            last_issued <= 1'b0;
            rd_pend     <= 1'b0;
            rd_addr_q   <= '0;
            ebuf_x      <= '0;
            ebuf_y      <= '0;
            tall_q      <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
        end else if (start) begin
            oam_addr    <= '0;
            last_issued <= 1'b0;
            rd_pend     <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            tall_q      <= tall;
        end else if (scanning) begin
            rd_pend   <= !last_issued;
            rd_addr_q <= oam_addr;
            if (!last_issued) begin
                if (oam_addr == LAST_ADDR) begin
                    last_issued <= 1'b1;
                end else begin
                    oam_addr <= oam_addr + ADDR_W'(1);
                end
            end
            if (rd_pend && !rd_addr_q[0]) begin
                ebuf_x <= oam_d_in[15:8];
                ebuf_y <= oam_d_in[7:0];
            end
            if (odd_visible) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + COUNT_W'(1);
                end
            end
        end else begin
            rd_pend <= 1'b0;
        end
    end

    // Registered query result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_hit  <= 1'b0;
            q_data <= '0;
        end else begin
            q_hit  <= do_query;
            q_data <= hit_data;
        end
    end

endmodule
